ex_stage_pipe: RTL and testbench

- Parametrised, handshaked execute stage for the pipelined core.
- Successor to the single-cycle EX block: XLEN-generic, registered output, valid/ready on both sides, and a branch-decision output.
- Adds an iterative multiply/divide unit (RV M-extension) that stalls the stage for multiple cycles.
- Sits between the ID/EX register and the MEM stage.

---
 rtl/ex_stage_pipe.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Handshaked execute stage: single-cycle ALU/branch/address ops plus optional iterative mul/div.
// Define ECNU_EX_MULDIV_EN to build the M-extension unit; otherwise M ops return 0 with illegal_op.
module ex_stage_pipe #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DIV_RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      operation,
  input  logic [2:0]      funct3,
  input  logic            sub_ctrl,
  input  logic            muldiv_ctrl,
  input  logic [XLEN-1:0] data_rs1,
  input  logic [XLEN-1:0] data_rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] addr_mem,
  output logic [XLEN-1:0] jmp_to,
  output logic            jmp_en
`ifndef ECNU_EX_MULDIV_EN
  ,
  output logic            illegal_op
`endif
);

  if (!((XLEN == 32 || XLEN == 64) && (DIV_RADIX_BITS == 1 || DIV_RADIX_BITS == 2)))
  begin : gen_bad_param
    $error("ex_stage_pipe: unsupported XLEN/DIV_RADIX_BITS");
  end

  localparam int unsigned ShW = $clog2(XLEN);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;
  state_e state_q, state_d;

  logic out_free, accept, is_muldiv, load_alu;
  assign out_free  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_muldiv = (operation == OpcOp) && muldiv_ctrl;

  // ---------------- single-cycle datapath ----------------
  logic [XLEN-1:0] op_b, sum_ri, alu_res, alu_tgt;
  logic [ShW-1:0]  shamt;
  logic            alu_jmp, alu_ill;

  assign sum_ri = data_rs1 + imm;

  always_comb begin
    op_b    = (operation == OpcOp) ? data_rs2 : imm;
    shamt   = op_b[ShW-1:0];
    alu_res = '0;
    alu_tgt = pc + imm;
    alu_jmp = 1'b0;
    alu_ill = 1'b0;
    case (operation)
      OpcOp, OpcOpImm: begin
        case (funct3)
          3'd0: alu_res = (operation == OpcOp && sub_ctrl) ? data_rs1 - op_b : data_rs1 + op_b;
          3'd1: alu_res = data_rs1 << shamt;
          3'd2: alu_res = {{(XLEN-1){1'b0}}, $signed(data_rs1) < $signed(op_b)};
          3'd3: alu_res = {{(XLEN-1){1'b0}}, data_rs1 < op_b};
          3'd4: alu_res = data_rs1 ^ op_b;
          3'd5: alu_res = sub_ctrl ? $unsigned($signed(data_rs1) >>> shamt) : data_rs1 >> shamt;
          3'd6: alu_res = data_rs1 | op_b;
          default: alu_res = data_rs1 & op_b;
        endcase
`ifndef ECNU_EX_MULDIV_EN
        if (is_muldiv) begin
          alu_res = '0;
          alu_ill = 1'b1;
        end
`endif
      end
      OpcLui:   alu_res = imm;
      OpcAuipc: alu_res = pc + imm;
      OpcJal: begin
        alu_res = pc + XLEN'(4);
        alu_jmp = 1'b1;
      end
      OpcJalr: begin
        alu_res = pc + XLEN'(4);
        alu_tgt = {sum_ri[XLEN-1:1], 1'b0};
        alu_jmp = 1'b1;
      end
      OpcBranch: begin
        case (funct3)
          3'd0: alu_jmp = (data_rs1 == data_rs2);
          3'd1: alu_jmp = (data_rs1 != data_rs2);
          3'd4: alu_jmp = ($signed(data_rs1) < $signed(data_rs2));
          3'd5: alu_jmp = ($signed(data_rs1) >= $signed(data_rs2));
          3'd6: alu_jmp = (data_rs1 < data_rs2);
          3'd7: alu_jmp = (data_rs1 >= data_rs2);
          default: alu_jmp = 1'b0;
        endcase
      end
      OpcLoad, OpcStore: alu_res = data_rs2;
      default: alu_res = '0;
    endcase
  end

`ifdef ECNU_EX_MULDIV_EN
  assign load_alu = accept && !is_muldiv;

  // ---------------- iterative multiply / divide ----------------
  localparam int unsigned Iters = XLEN / DIV_RADIX_BITS;
  localparam int unsigned CntW  = $clog2(Iters + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, dividend_q, dividend_d;
  logic [XLEN-1:0] addr_pend_q, addr_pend_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d, div0_q, div0_d;

  logic            a_sgn, b_sgn, load_md;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] st_h, st_l, st_diff;
  logic [XLEN:0]   st_sum, st_rsh;
  logic            st_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   md_res;

  assign load_md = (state_q == StBusy) && (cnt_q == '0) && out_free;

  always_comb begin
    a_sgn = (funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd4 || funct3 == 3'd6)
            && data_rs1[XLEN-1];
    b_sgn = (funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd6) && data_rs2[XLEN-1];
    a_mag = a_sgn ? -data_rs1 : data_rs1;
    b_mag = b_sgn ? -data_rs2 : data_rs2;
  end

  // One radix step per loop pass: shift-add for MUL*, restoring subtract for DIV/REM.
  always_comb begin
    st_h    = hi_q;
    st_l    = lo_q;
    st_sum  = '0;
    st_rsh  = '0;
    st_diff = '0;
    st_ge   = 1'b0;
    for (int i = 0; i < int'(DIV_RADIX_BITS); i++) begin
      if (!f3_q[2]) begin
        st_sum = {1'b0, st_h} + (st_l[0] ? {1'b0, mcand_q} : '0);
        st_h   = st_sum[XLEN:1];
        st_l   = {st_sum[0], st_l[XLEN-1:1]};
      end else begin
        st_rsh  = {st_h, st_l[XLEN-1]};
        st_ge   = st_rsh >= {1'b0, mcand_q};
        st_diff = st_rsh[XLEN-1:0] - mcand_q;
        st_h    = st_ge ? st_diff : st_rsh[XLEN-1:0];
        st_l    = {st_l[XLEN-2:0], st_ge};
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_d     = mcand_q;
    dividend_d  = dividend_q;
    addr_pend_d = addr_pend_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    div0_d      = div0_q;
    if (accept && is_muldiv) begin
      cnt_d       = CntW'(Iters);
      hi_d        = '0;
      lo_d        = funct3[2] ? a_mag : b_mag;
      mcand_d     = funct3[2] ? b_mag : a_mag;
      dividend_d  = data_rs1;
      addr_pend_d = sum_ri;
      f3_d        = funct3;
      neg_d       = (funct3[2] && funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
      div0_d      = (data_rs2 == '0);
    end else if (state_q == StBusy && cnt_q != '0) begin
      hi_d  = st_h;
      lo_d  = st_l;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      dividend_q  <= '0;
      addr_pend_q <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcand_q     <= mcand_d;
      dividend_q  <= dividend_d;
      addr_pend_q <= addr_pend_d;
      f3_q        <= f3_d;
      neg_q       <= neg_d;
      div0_q      <= div0_d;
    end
  end

  always_comb begin
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    case (f3_q)
      3'd0:       md_res = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       md_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: md_res = div0_q ? '1 : (neg_q ? -lo_q : lo_q);
      default:    md_res = div0_q ? dividend_q : (neg_q ? -hi_q : hi_q);
    endcase
  end
`else
  assign load_alu = accept;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef ECNU_EX_MULDIV_EN
      StIdle: if (accept && is_muldiv && !flush) state_d = StBusy;
      StBusy: if (flush || load_md) state_d = StIdle;
`else
      StIdle: state_d = StIdle;
      StBusy: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle) && out_free;
  end

  // ---------------- output register ----------------
  // jmp_en/illegal_op drop with out_valid so a consumed redirect is never seen twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      addr_mem   <= '0;
      jmp_to     <= '0;
      jmp_en     <= 1'b0;
`ifndef ECNU_EX_MULDIV_EN
      illegal_op <= 1'b0;
`endif
    end else if (flush) begin
      out_valid  <= 1'b0;
      jmp_en     <= 1'b0;
`ifndef ECNU_EX_MULDIV_EN
      illegal_op <= 1'b0;
`endif
    end else if (load_alu) begin
      out_valid  <= 1'b1;
      data_out   <= alu_res;
      addr_mem   <= sum_ri;
      jmp_to     <= alu_tgt;
      jmp_en     <= alu_jmp;
`ifndef ECNU_EX_MULDIV_EN
      illegal_op <= alu_ill;
`endif
`ifdef ECNU_EX_MULDIV_EN
    end else if (load_md) begin
      out_valid  <= 1'b1;
      data_out   <= md_res;
      addr_mem   <= addr_pend_q;
      jmp_to     <= '0;
      jmp_en     <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      jmp_en     <= 1'b0;
`ifndef ECNU_EX_MULDIV_EN
      illegal_op <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe (XLEN=32, radix 1); adapts to the ECNU_EX_MULDIV_EN build.
module tb_ex_stage_pipe;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  logic            clk, rst, flush, in_valid, in_ready, sub_ctrl, muldiv_ctrl;
  logic [6:0]      operation;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data_rs1, data_rs2, pc, imm, data_out, addr_mem, jmp_to;
  logic            out_valid, out_ready, jmp_en;
`ifndef ECNU_EX_MULDIV_EN
  logic            illegal_op;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ex_stage_pipe #(.XLEN(XLEN), .DIV_RADIX_BITS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .funct3     (funct3),
    .sub_ctrl   (sub_ctrl),
    .muldiv_ctrl(muldiv_ctrl),
    .data_rs1   (data_rs1),
    .data_rs2   (data_rs2),
    .pc         (pc),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .addr_mem   (addr_mem),
    .jmp_to     (jmp_to),
    .jmp_en     (jmp_en)
`ifndef ECNU_EX_MULDIV_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic sub,
                       input logic md, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im);
    operation = opc; funct3 = f3; sub_ctrl = sub; muldiv_ctrl = md;
    data_rs1 = a; data_rs2 = b; pc = p; imm = im;
    in_valid = 1'b1;
  endtask

  // Present one op for a single edge; returns 1 ns after that edge.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic sub,
                       input logic md, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im);
    drive(opc, f3, sub, md, a, b, p, im);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

`ifdef ECNU_EX_MULDIV_EN
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    int ready_seen;
    issue(OP, f3, 1'b0, 1'b1, a, b, 32'h0, 32'h0);
    n = 1;
    ready_seen = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) ready_seen++;
      @(posedge clk);
      #1 n++;
    end
    check({tag, " latency"}, 64'(n), 64'd34);
    check({tag, " in_ready busy"}, 64'(ready_seen), 64'd0);
    check(tag, 64'(data_out), 64'(exp));
  endtask
`endif

  initial begin
    int stray;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operation = '0; funct3 = '0; sub_ctrl = 1'b0; muldiv_ctrl = 1'b0;
    data_rs1 = '0; data_rs2 = '0; pc = '0; imm = '0;
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset data_out", 64'(data_out), 64'd0);
    check("reset jmp_en", 64'(jmp_en), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    issue(OP, 3'd0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0);
    check("add valid", 64'(out_valid), 64'd1);
    check("add", 64'(data_out), 64'h8000_0000);
    issue(OP, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
    check("sub", 64'(data_out), 64'hFFFF_FFFE);
    issue(BRANCH, 3'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
    check("blt jmp_en", 64'(jmp_en), 64'd1);
    check("blt jmp_to", 64'(jmp_to), 64'h120);
    issue(BRANCH, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
    check("bltu jmp_en", 64'(jmp_en), 64'd0);
    issue(OPIMM, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h404);
    check("srai", 64'(data_out), 64'hF800_0000);
    issue(JALR, 3'd0, 1'b0, 1'b0, 32'h1001, 32'h0, 32'h200, 32'h10);
    check("jalr link", 64'(data_out), 64'h204);
    check("jalr target", 64'(jmp_to), 64'h1010);
    check("jalr jmp_en", 64'(jmp_en), 64'd1);
    issue(LOAD, 3'd2, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0, 32'hFFFF_FFFC);
    check("load addr", 64'(addr_mem), 64'hFFC);
    check("load clears jmp_en", 64'(jmp_en), 64'd0);
    issue(STORE, 3'd2, 1'b0, 1'b0, 32'h2000, 32'hDEAD_BEEF, 32'h0, 32'h8);
    check("store data", 64'(data_out), 64'hDEAD_BEEF);
    check("store addr", 64'(addr_mem), 64'h2008);
    issue(LUI, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1234_5000);
    check("lui", 64'(data_out), 64'h1234_5000);
    issue(7'b1111111, 3'd0, 1'b0, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0);
    check("unknown valid", 64'(out_valid), 64'd1);
    check("unknown data", 64'(data_out), 64'd0);

`ifdef ECNU_EX_MULDIV_EN
    run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("div by zero", 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_md("rem by zero", 3'd6, 32'd7, 32'd0, 32'd7);
    run_md("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_md("mul", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    run_md("mulh", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    run_md("div signed", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_md("rem signed", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
`else
    issue(OP, 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("m-op 1 cycle", 64'(out_valid), 64'd1);
    check("m-op data", 64'(data_out), 64'd0);
    check("m-op illegal", 64'(illegal_op), 64'd1);
    @(posedge clk);
    #1 check("illegal pulse ends", 64'(illegal_op), 64'd0);
`endif

    // Backpressure: result held for 5 cycles, next op accepted as out_ready rises.
    out_ready = 1'b0;
    issue(OP, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0);
    check("bp load", 64'(data_out), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp hold data", 64'(data_out), 64'd3);
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    drive(OP, 3'd4, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0);
    #1 check("bp ready rises", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp next op", 64'(data_out), 64'h0FF0_0FF0);

    // Flush beats a simultaneous accept.
    flush = 1'b1;
    issue(OP, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9, 32'h0, 32'h0);
    flush = 1'b0;
    check("flush vs accept", 64'(out_valid), 64'd0);

`ifdef ECNU_EX_MULDIV_EN
    issue(OP, 3'd5, 1'b0, 1'b1, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush divu valid", 64'(out_valid), 64'd0);
    check("flush divu ready", 64'(in_ready), 64'd1);
    stray = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) stray++;
    end
    check("flush no late result", 64'(stray), 64'd0);

    issue(OP, 3'd0, 1'b0, 1'b1, 32'd3, 32'd4, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst mid-mul valid", 64'(out_valid), 64'd0);
    check("rst mid-mul data", 64'(data_out), 64'd0);
    check("rst mid-mul ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run_md("mul after reset", 3'd0, 32'd3, 32'd4, 32'd12);
`else
    stray = 0;
    out_ready = 1'b0;
    issue(OP, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 64'(out_valid), 64'd0);
    check("async rst data", 64'(data_out), 64'd0);
    check("async rst ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 issue(OP, 3'd7, 1'b0, 1'b0, 32'hFF, 32'h0F, 32'h0, 32'h0);
    check("and after reset", 64'(data_out), 64'h0F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
